// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 note decoder.
//   - scan-code constants (prefixes, octave keys, the 13 note keys)
//   - prefix-tracking FSM state encoding
//   - helpers: lowest held key, MIDI-style note code
package ps2_pkg;

    localparam int NUM_NOTES = 13;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] OCT_DN     = 8'h1A;  // Z
    localparam logic [7:0] OCT_UP     = 8'h22;  // X

    // Note keys, named by the chromatic index they produce.
    localparam logic [7:0] KEY_N0  = 8'h1C;  // A  C
    localparam logic [7:0] KEY_N1  = 8'h1D;  // W  C#
    localparam logic [7:0] KEY_N2  = 8'h1B;  // S  D
    localparam logic [7:0] KEY_N3  = 8'h24;  // E  D#
    localparam logic [7:0] KEY_N4  = 8'h23;  // D  E
    localparam logic [7:0] KEY_N5  = 8'h2B;  // F  F
    localparam logic [7:0] KEY_N6  = 8'h2C;  // T  F#
    localparam logic [7:0] KEY_N7  = 8'h34;  // G  G
    localparam logic [7:0] KEY_N8  = 8'h35;  // Y  G#
    localparam logic [7:0] KEY_N9  = 8'h33;  // H  A
    localparam logic [7:0] KEY_N10 = 8'h3C;  // U  A#
    localparam logic [7:0] KEY_N11 = 8'h3B;  // J  B
    localparam logic [7:0] KEY_N12 = 8'h42;  // K  C'

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [NUM_NOTES-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    // 12*(octave+1) + idx; max 108, so 7 bits always suffice.
    function automatic logic [6:0] midi_code(input logic [2:0] oct, input logic [3:0] idx);
        logic [7:0] t;
        t = (8'(oct) + 8'd1) * 8'd12 + 8'(idx);
        return t[6:0];
    endfunction

endpackage

// File: rtl/ps2_scan_to_note.sv
// ps2_scan_to_note: purely combinational scan-code classifier.
//   code_i      : scan-code byte
//   is_note_o   : byte is one of the 13 note keys
//   idx_o       : chromatic index of that key (0 when not a note)
//   is_oct_up_o : byte is the octave-up key
//   is_oct_dn_o : byte is the octave-down key
module ps2_scan_to_note
    import ps2_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       is_note_o,
    output logic [3:0] idx_o,
    output logic       is_oct_up_o,
    output logic       is_oct_dn_o
);

    always_comb begin
        is_note_o = 1'b1;
        idx_o     = 4'd0;
        case (code_i)
            KEY_N0:  idx_o = 4'd0;
            KEY_N1:  idx_o = 4'd1;
            KEY_N2:  idx_o = 4'd2;
            KEY_N3:  idx_o = 4'd3;
            KEY_N4:  idx_o = 4'd4;
            KEY_N5:  idx_o = 4'd5;
            KEY_N6:  idx_o = 4'd6;
            KEY_N7:  idx_o = 4'd7;
            KEY_N8:  idx_o = 4'd8;
            KEY_N9:  idx_o = 4'd9;
            KEY_N10: idx_o = 4'd10;
            KEY_N11: idx_o = 4'd11;
            KEY_N12: idx_o = 4'd12;
            default: is_note_o = 1'b0;
        endcase
    end

    assign is_oct_up_o = (code_i == OCT_UP);
    assign is_oct_dn_o = (code_i == OCT_DN);

endmodule

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: turns a PS/2 scan-code byte stream into piano note events.
//   clk, reset        : clock, synchronous active-high reset
//   scan_code_ready   : one-cycle strobe qualifying scan_code
//   scan_code         : received byte
//   note_evt          : one-cycle press/release pulse
//   note_on, note_idx : direction and index of that event
//   keys_held         : bitmap of held note keys
//   octave            : current octave (saturating 0..OCT_MAX)
//   active_valid      : a note is sounding
//   active_note       : 12*(octave+1) + active index (last-pressed wins)
// All outputs are registered, one cycle after the strobe.
module ps2_note_decoder
    import ps2_pkg::*;
#(
    parameter int OCT_DEFAULT = 4,
    parameter int OCT_MAX     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_code_ready,
    input  logic [7:0]           scan_code,
    output logic                 note_evt,
    output logic                 note_on,
    output logic [3:0]           note_idx,
    output logic [NUM_NOTES-1:0] keys_held,
    output logic [2:0]           octave,
    output logic                 active_valid,
    output logic [6:0]           active_note
);

    state_e               state_q, state_d;
    logic [NUM_NOTES-1:0] keys_q, keys_d;
    logic                 evt_q, evt_d;
    logic                 on_q, on_d;
    logic [3:0]           idx_q, idx_d;
    logic [2:0]           oct_q, oct_d;
    logic                 act_vld_q, act_vld_d;
    logic [3:0]           act_idx_q, act_idx_d;
    logic [6:0]           act_note_q, act_note_d;

    logic       is_note, is_oct_up, is_oct_dn;
    logic [3:0] map_idx;

    ps2_scan_to_note u_map (
        .code_i      (scan_code),
        .is_note_o   (is_note),
        .idx_o       (map_idx),
        .is_oct_up_o (is_oct_up),
        .is_oct_dn_o (is_oct_dn)
    );

    always_comb begin
        state_d   = state_q;
        keys_d    = keys_q;
        evt_d     = 1'b0;
        on_d      = on_q;
        idx_d     = idx_q;
        oct_d     = oct_q;
        act_vld_d = act_vld_q;
        act_idx_d = act_idx_q;

        if (scan_code_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == BREAK_CODE) begin
                        state_d = ST_BRK;
                    end else if (scan_code == EXT_CODE) begin
                        state_d = ST_EXT;
                    end else if (is_note) begin
                        // Typematic repeats of a held key are swallowed.
                        if (!keys_q[map_idx]) begin
                            keys_d[map_idx] = 1'b1;
                            evt_d     = 1'b1;
                            on_d      = 1'b1;
                            idx_d     = map_idx;
                            act_vld_d = 1'b1;
                            act_idx_d = map_idx;
                        end
                    end else if (is_oct_up) begin
                        if (oct_q < 3'(OCT_MAX)) oct_d = oct_q + 3'd1;
                    end else if (is_oct_dn) begin
                        if (oct_q != 3'd0) oct_d = oct_q - 3'd1;
                    end
                end
                ST_BRK: begin
                    // Repeated F0 keeps the break prefix armed.
                    if (scan_code != BREAK_CODE) begin
                        state_d = ST_IDLE;
                        if (is_note && keys_q[map_idx]) begin
                            keys_d[map_idx] = 1'b0;
                            evt_d = 1'b1;
                            on_d  = 1'b0;
                            idx_d = map_idx;
                            // Only releasing the sounding note moves the active index.
                            if (act_vld_q && act_idx_q == map_idx) begin
                                if (keys_d != '0) act_idx_d = lowest_set(keys_d);
                                else              act_vld_d = 1'b0;
                            end
                        end
                    end
                end
                ST_EXT:     state_d = (scan_code == BREAK_CODE) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        act_note_d = midi_code(oct_d, act_idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            keys_q     <= '0;
            evt_q      <= 1'b0;
            on_q       <= 1'b0;
            idx_q      <= 4'd0;
            oct_q      <= 3'(OCT_DEFAULT);
            act_vld_q  <= 1'b0;
            act_idx_q  <= 4'd0;
            act_note_q <= midi_code(3'(OCT_DEFAULT), 4'd0);
        end else begin
            state_q    <= state_d;
            keys_q     <= keys_d;
            evt_q      <= evt_d;
            on_q       <= on_d;
            idx_q      <= idx_d;
            oct_q      <= oct_d;
            act_vld_q  <= act_vld_d;
            act_idx_q  <= act_idx_d;
            act_note_q <= act_note_d;
        end
    end

    assign note_evt     = evt_q;
    assign note_on      = on_q;
    assign note_idx     = idx_q;
    assign keys_held    = keys_q;
    assign octave       = oct_q;
    assign active_valid = act_vld_q;
    assign active_note  = act_note_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
module tb_ps2_note_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_code_ready = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        note_evt, note_on, active_valid;
    logic [3:0]  note_idx;
    logic [12:0] keys_held;
    logic [2:0]  octave;
    logic [6:0]  active_note;

    always #5 clk = ~clk;

    ps2_note_decoder #(.OCT_DEFAULT(4), .OCT_MAX(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .scan_code_ready (scan_code_ready),
        .scan_code       (scan_code),
        .note_evt        (note_evt),
        .note_on         (note_on),
        .note_idx        (note_idx),
        .keys_held       (keys_held),
        .octave          (octave),
        .active_valid    (active_valid),
        .active_note     (active_note)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: key table straight from the key map, keyboard state as plain values.
    byte unsigned note_code[13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                   8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
    bit  held[13];
    int  m_oct, m_ai;
    bit  m_av;
    bit  saw_f0, saw_e0;          // pending prefix bytes
    bit  x_evt, x_on;
    int  x_idx;

    function automatic int lookup(input byte unsigned b);
        for (int i = 0; i < 13; i++) if (note_code[i] == b) return i;
        return -1;
    endfunction

    function automatic int held_mask();
        int m = 0;
        for (int i = 0; i < 13; i++) if (held[i]) m += (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) held[i] = 0;
        m_oct = 4; m_ai = 0; m_av = 0;
        saw_f0 = 0; saw_e0 = 0;
        x_evt = 0; x_on = 0; x_idx = 0;
    endtask

    task automatic model_byte(input byte unsigned b);
        int n;
        n = lookup(b);
        x_evt = 0;
        if (saw_e0) begin
            // Extended sequences never touch notes.
            if (!saw_f0 && b == 8'hF0) saw_f0 = 1;
            else begin saw_e0 = 0; saw_f0 = 0; end
        end else if (saw_f0) begin
            if (b != 8'hF0) begin
                saw_f0 = 0;
                if (n >= 0 && held[n]) begin
                    held[n] = 0;
                    x_evt = 1; x_on = 0; x_idx = n;
                    if (m_av && m_ai == n) begin
                        m_av = 0;
                        for (int i = 12; i >= 0; i--)
                            if (held[i]) begin m_av = 1; m_ai = i; end
                    end
                end
            end
        end else begin
            if (b == 8'hF0) saw_f0 = 1;
            else if (b == 8'hE0) saw_e0 = 1;
            else if (n >= 0) begin
                if (!held[n]) begin
                    held[n] = 1;
                    x_evt = 1; x_on = 1; x_idx = n;
                    m_av = 1; m_ai = n;
                end
            end else if (b == 8'h22 && m_oct < 7) m_oct++;
            else if (b == 8'h1A && m_oct > 0) m_oct--;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " note_evt"}, 32'(note_evt), 32'(x_evt));
        if (x_evt) begin
            chk({tag, " note_on"}, 32'(note_on), 32'(x_on));
            chk({tag, " note_idx"}, 32'(note_idx), 32'(x_idx));
        end
        chk({tag, " keys_held"}, 32'(keys_held), 32'(held_mask()));
        chk({tag, " octave"}, 32'(octave), 32'(m_oct));
        chk({tag, " active_valid"}, 32'(active_valid), 32'(m_av));
        if (m_av) chk({tag, " active_note"}, 32'(active_note), 32'(12 * (m_oct + 1) + m_ai));
    endtask

    task automatic send(input string tag, input byte unsigned b);
        @(negedge clk);
        scan_code_ready = 1'b1;
        scan_code = b;
        @(negedge clk);
        scan_code_ready = 1'b0;
        scan_code = 8'h00;
        model_byte(b);
        check_all(tag);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        x_evt = 0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        scan_code_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_all("reset");
        chk("reset note_on", 32'(note_on), 0);
        chk("reset note_idx", 32'(note_idx), 0);
        chk("reset active_note", 32'(active_note), 60);
    endtask

    initial begin
        int r;
        byte unsigned b;
        model_reset();
        repeat (2) @(negedge clk);

        // First press from reset
        do_reset();
        send("press A", 8'h1C);
        chk("press A active_note", 32'(active_note), 60);

        // Typematic repeats then release
        do_reset();
        send("rep1", 8'h1C);
        send("rep2", 8'h1C);
        send("rep3", 8'h1C);
        send("rel F0", 8'hF0);
        send("rel 1C", 8'h1C);
        idle_check("idle after release");

        // Last-pressed wins, fall back to lowest held
        do_reset();
        send("two A", 8'h1C);
        send("two J", 8'h3B);
        chk("two J note", 32'(active_note), 71);
        send("two F0", 8'hF0);
        send("two relJ", 8'h3B);
        chk("two back note", 32'(active_note), 60);

        // Octave saturation and retune
        do_reset();
        for (int i = 0; i < 5; i++) send("oct up", 8'h22);
        chk("oct sat", 32'(octave), 7);
        send("K high", 8'h42);
        chk("K note", 32'(active_note), 108);
        send("oct dn", 8'h1A);
        chk("retune", 32'(active_note), 96);
        for (int i = 0; i < 9; i++) send("oct dn low", 8'h1A);
        chk("oct floor", 32'(octave), 0);

        // Extended and unmapped bytes, stacked breaks
        do_reset();
        send("held S", 8'h1B);
        send("ext E0", 8'hE0);
        send("ext 1C", 8'h1C);
        send("extb E0", 8'hE0);
        send("extb F0", 8'hF0);
        send("extb 1B", 8'h1B);
        send("unmapped", 8'h15);
        send("ff F0a", 8'hF0);
        send("ff F0b", 8'hF0);
        send("ff 23", 8'h23);
        send("post ff press", 8'h23);

        // Reset discards a pending break prefix
        do_reset();
        send("pre F0", 8'hF0);
        do_reset();
        send("after rst", 8'h1C);
        chk("after rst on", 32'(note_on), 1);

        // Randomized byte stream
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 19));
            if (r < 9)       b = note_code[$urandom_range(0, 12)];
            else if (r < 13) b = 8'hF0;
            else if (r < 15) b = 8'hE0;
            else if (r < 16) b = 8'h1A;
            else if (r < 17) b = 8'h22;
            else             b = 8'($urandom_range(0, 255));
            send("rand", b);
            if ($urandom_range(0, 15) == 0) idle_check("rand idle");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
